// File: rtl/m5_writeback_pkg.sv
// rtl/m5_writeback_pkg.sv - shared widths for the multiplier writeback stage
package m5_writeback_pkg;

    localparam int REG_SIZE = 32;
    localparam int DST_W    = 5;

    // Packed entry payload {overflow, zero, dst, result}; the valid bit lives beside it in m5_entry.
    localparam int MUL_ENTRY_W = REG_SIZE + 7;

    function automatic int payload_w(input int result_w);
        return result_w + 2 + DST_W;
    endfunction

endpackage

// File: rtl/m5_writeback_if.sv
// rtl/m5_writeback_if.sv - M4 input, register-file write port and hazard report bundle
interface m5_writeback_if
    import m5_writeback_pkg::*;
#(
    parameter int WIDTH = REG_SIZE
) ();

    logic             in_valid;
    logic [WIDTH-1:0] m4result;
    logic             zero;
    logic             overflow;
    logic [DST_W-1:0] dst;
    logic             in_ready;
    logic             flush;
    logic             wb_grant;
    logic             wb_req;
    logic             wb_we;
    logic [WIDTH-1:0] wb_data;
    logic [DST_W-1:0] wb_dst;
    logic             wb_zero;
    logic             exc_overflow;
    logic [1:0]       pend_valid;
    logic [DST_W-1:0] pend_dst0;
    logic [DST_W-1:0] pend_dst1;

    modport master (
        output in_valid, m4result, zero, overflow, dst, flush, wb_grant,
        input  in_ready, wb_req, wb_we, wb_data, wb_dst, wb_zero,
        input  exc_overflow, pend_valid, pend_dst0, pend_dst1
    );

    modport slave (
        input  in_valid, m4result, zero, overflow, dst, flush, wb_grant,
        output in_ready, wb_req, wb_we, wb_data, wb_dst, wb_zero,
        output exc_overflow, pend_valid, pend_dst0, pend_dst1
    );

endinterface

// File: rtl/m5_writeback_entry.sv
// rtl/m5_writeback_entry.sv - m5_entry: one buffered result with load and clear enables
module m5_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clear wins over load so a flush can never leave a stale entry valid.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/m5_writeback.sv
// rtl/m5_writeback.sv - multiplier writeback: head + skid buffer feeding the register-file port
module m5_writeback
    import m5_writeback_pkg::*;
#(
    parameter int WIDTH = REG_SIZE
) (
    input  logic           clk,
    input  logic           reset,
    m5_writeback_if.slave  bus
);

    localparam int PW = payload_w(WIDTH);

    logic             w_head_valid;
    logic             w_skid_valid;
    logic [PW-1:0]    w_head_data;
    logic [PW-1:0]    w_skid_data;
    logic [PW-1:0]    w_in_data;
    logic             w_head_ov;
    logic             w_head_zero;
    logic [DST_W-1:0] w_head_dst;
    logic             w_accept;
    logic             w_head_retire;
    logic             w_head_load;
    logic             w_head_clear;
    logic [PW-1:0]    w_head_d;
    logic             w_skid_load;
    logic             w_skid_clear;

    assign w_in_data   = {bus.overflow, bus.zero, bus.dst, bus.m4result};
    assign w_head_ov   = w_head_data[PW-1];
    assign w_head_zero = w_head_data[PW-2];
    assign w_head_dst  = w_head_data[PW-3 -: DST_W];

    // in_ready depends only on registered state, so M4 never sees a combinational loop.
    assign w_accept      = bus.in_valid & ~w_skid_valid & ~bus.flush;
    assign w_head_retire = w_head_valid & (bus.wb_grant | w_head_ov | (w_head_dst == '0));

    always_comb begin
        w_head_load  = 1'b0;
        w_head_clear = 1'b0;
        w_head_d     = w_in_data;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (bus.flush) begin
            w_head_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_head_retire) begin
            if (w_skid_valid) begin
                w_head_load  = 1'b1;
                w_head_d     = w_skid_data;
                w_skid_clear = 1'b1;
            end else if (w_accept) begin
                w_head_load  = 1'b1;
            end else begin
                w_head_clear = 1'b1;
            end
        end else if (w_accept) begin
            if (w_head_valid) begin
                w_skid_load = 1'b1;
            end else begin
                w_head_load = 1'b1;
            end
        end
    end

    m5_entry #(.W(PW)) u_head (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_data  (w_head_d),
        .o_valid (w_head_valid),
        .o_data  (w_head_data)
    );

    m5_entry #(.W(PW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    assign bus.in_ready     = ~w_skid_valid;
    assign bus.wb_req       = w_head_valid & ~w_head_ov & (w_head_dst != '0);
    // Reset and flush both squash side effects of the cycle they occur in.
    assign bus.wb_we        = bus.wb_req & bus.wb_grant & ~bus.flush & ~reset;
    assign bus.exc_overflow = w_head_valid & w_head_ov & ~bus.flush & ~reset;
    assign bus.wb_data      = w_head_data[WIDTH-1:0];
    assign bus.wb_dst       = w_head_dst;
    assign bus.wb_zero      = w_head_zero;
    assign bus.pend_valid   = {w_skid_valid, w_head_valid};
    assign bus.pend_dst0    = w_head_dst;
    assign bus.pend_dst1    = w_skid_data[PW-3 -: DST_W];

endmodule

// File: tb/tb_m5_writeback.sv
// tb/tb_m5_writeback.sv - directed vector table plus randomized queue-model comparison
module tb_m5_writeback;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    m5_writeback_if #(.WIDTH(32)) bus ();

    m5_writeback #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic [4:0]  dst;
        logic        fl;
        logic        gr;
        logic        rdy;
        logic        req;
        logic        we;
        logic        exc;
        logic [1:0]  pv;
        logic        chk_d;
        logic [31:0] data;
        logic [4:0]  wdst;
        logic        ez;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic [4:0]  dst;
    } ent_t;

    vec_t vecs[$];
    ent_t model_q[$];

    task automatic add(input logic rst, input logic iv, input logic [31:0] res, input logic z,
                       input logic ov, input logic [4:0] dst, input logic fl, input logic gr,
                       input logic rdy, input logic req, input logic we, input logic exc,
                       input logic [1:0] pv, input logic chk_d, input logic [31:0] data,
                       input logic [4:0] wdst, input logic ez);
        vec_t v;
        v.rst = rst; v.iv = iv; v.res = res; v.z = z; v.ov = ov; v.dst = dst; v.fl = fl; v.gr = gr;
        v.rdy = rdy; v.req = req; v.we = we; v.exc = exc; v.pv = pv;
        v.chk_d = chk_d; v.data = data; v.wdst = wdst; v.ez = ez;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [31:0] res, input logic z,
                         input logic ov, input logic [4:0] dst, input logic fl, input logic gr);
        reset        = rst;
        bus.in_valid = iv;
        bus.m4result = res;
        bus.zero     = z;
        bus.overflow = ov;
        bus.dst      = dst;
        bus.flush    = fl;
        bus.wb_grant = gr;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        //   rst iv res       z  ov dst fl gr | rdy req we exc pv  chk data     wdst ez
        add(1, 0, 32'h0,    0, 0, 0,  0, 0,   1, 0, 0, 0, 2'd0, 1, 32'h0,  0,  0);
        add(0, 1, 32'h6,    0, 0, 3,  0, 1,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 1,   1, 1, 1, 0, 2'd1, 1, 32'h6,  3,  0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 1, 32'h11,   0, 0, 1,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 1, 32'h22,   0, 0, 2,  0, 0,   1, 1, 0, 0, 2'd1, 1, 32'h11, 1,  0);
        add(0, 1, 32'h33,   0, 0, 3,  0, 0,   0, 1, 0, 0, 2'd3, 1, 32'h11, 1,  0);
        add(0, 1, 32'h33,   0, 0, 3,  0, 1,   0, 1, 1, 0, 2'd3, 1, 32'h11, 1,  0);
        add(0, 1, 32'h33,   0, 0, 3,  0, 1,   1, 1, 1, 0, 2'd1, 1, 32'h22, 2,  0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 1,   1, 1, 1, 0, 2'd1, 1, 32'h33, 3,  0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 1, 32'h55,   0, 1, 5,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 1, 32'h66,   1, 0, 6,  0, 0,   1, 0, 0, 1, 2'd1, 1, 32'h55, 5,  0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 1,   1, 1, 1, 0, 2'd1, 1, 32'h66, 6,  1);
        add(0, 1, 32'h77,   0, 0, 0,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 0,   1, 0, 0, 0, 2'd1, 1, 32'h77, 0,  0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 1, 32'hA1,   0, 0, 7,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 1, 32'hA2,   0, 0, 8,  0, 0,   1, 1, 0, 0, 2'd1, 1, 32'hA1, 7,  0);
        add(0, 1, 32'hA3,   0, 0, 9,  1, 1,   0, 1, 0, 0, 2'd3, 1, 32'hA1, 7,  0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 1, 32'hB1,   0, 1, 4,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 0, 32'h0,    0, 0, 0,  1, 0,   1, 0, 0, 0, 2'd1, 1, 32'hB1, 4,  0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(0, 1, 32'hC1,   0, 0, 10, 0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);
        add(1, 0, 32'h0,    0, 0, 0,  0, 1,   1, 1, 0, 0, 2'd1, 1, 32'hC1, 10, 0);
        add(0, 0, 32'h0,    0, 0, 0,  0, 0,   1, 0, 0, 0, 2'd0, 0, 32'h0,  0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].iv, vecs[i].res, vecs[i].z, vecs[i].ov, vecs[i].dst,
                  vecs[i].fl, vecs[i].gr);
            #3;
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d wb_req", i), 32'(bus.wb_req), 32'(vecs[i].req));
            chk($sformatf("v%0d wb_we", i), 32'(bus.wb_we), 32'(vecs[i].we));
            chk($sformatf("v%0d exc_overflow", i), 32'(bus.exc_overflow), 32'(vecs[i].exc));
            chk($sformatf("v%0d pend_valid", i), 32'(bus.pend_valid), 32'(vecs[i].pv));
            if (vecs[i].chk_d) begin
                chk($sformatf("v%0d wb_data", i), bus.wb_data, vecs[i].data);
                chk($sformatf("v%0d wb_dst", i), 32'(bus.wb_dst), 32'(vecs[i].wdst));
                chk($sformatf("v%0d wb_zero", i), 32'(bus.wb_zero), 32'(vecs[i].ez));
                chk($sformatf("v%0d pend_dst0", i), 32'(bus.pend_dst0), 32'(vecs[i].wdst));
            end
        end

        // Randomized phase: a FIFO of at most two results is the reference.
        model_q.delete();
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_iv, r_z, r_ov, r_fl, r_gr;
            logic [31:0] r_res;
            logic [4:0]  r_dst;
            logic        hv, e_req, acc;
            ent_t        h;
            ent_t        n;
            @(posedge clk);
            #1;
            r_rst = ($urandom_range(0, 99) == 0);
            r_fl  = ($urandom_range(0, 29) == 0);
            r_iv  = ($urandom_range(0, 3) != 0);
            r_gr  = 1'($urandom_range(0, 1));
            r_ov  = ($urandom_range(0, 7) == 0);
            r_z   = 1'($urandom_range(0, 1));
            r_res = $urandom;
            r_dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive(r_rst, r_iv, r_res, r_z, r_ov, r_dst, r_fl, r_gr);
            #3;
            hv    = (model_q.size() > 0);
            h     = hv ? model_q[0] : '{res: 32'h0, z: 1'b0, ov: 1'b0, dst: 5'd0};
            e_req = hv && !h.ov && (h.dst != 5'd0);
            chk("rnd in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
            chk("rnd wb_req", 32'(bus.wb_req), 32'(e_req));
            chk("rnd wb_we", 32'(bus.wb_we), 32'(e_req && r_gr && !r_fl && !r_rst));
            chk("rnd exc_overflow", 32'(bus.exc_overflow), 32'(hv && h.ov && !r_fl && !r_rst));
            chk("rnd pend_valid", 32'(bus.pend_valid), 32'({model_q.size() > 1, hv}));
            if (e_req) begin
                chk("rnd wb_data", bus.wb_data, h.res);
                chk("rnd wb_zero", 32'(bus.wb_zero), 32'(h.z));
            end
            if (hv) chk("rnd pend_dst0", 32'(bus.pend_dst0), 32'(h.dst));
            if (model_q.size() > 1) chk("rnd pend_dst1", 32'(bus.pend_dst1), 32'(model_q[1].dst));

            if (r_rst || r_fl) begin
                model_q.delete();
            end else begin
                acc = r_iv && (model_q.size() < 2);
                if (hv && (r_gr || h.ov || h.dst == 5'd0)) void'(model_q.pop_front());
                if (acc) begin
                    n.res = r_res; n.z = r_z; n.ov = r_ov; n.dst = r_dst;
                    model_q.push_back(n);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
